// File: rtl/mem_access_unit.sv
// MEM-stage front end: maps byte/half/word loads and stores onto a word-addressed
// data memory, with a 2-cycle read-modify-write for sub-word stores.
module mem_access_unit #(
   parameter int unsigned ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_read,
   input  logic                     req_write,
   input  logic [1:0]               req_size,
   input  logic                     req_unsigned,
   input  logic [31:0]              req_addr,
   input  logic [31:0]              req_wdata,
   input  logic [31:0]              mem_rdata,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic [31:0]              load_data,
   output logic                     stall,
   output logic                     err,
   output logic [ERR_CNT_WIDTH-1:0] err_count
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      MERGE = 1'b1
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] lat_addr, lat_data;

   logic        any_req, err_c, legal;
   logic        is_load, is_word_store, is_sub_store;
   logic [4:0]  shift;
   logic [31:0] lane_mask, lane_raw, load_ext, merged;

   always_comb begin
      any_req = req_read | req_write;
      err_c   = (state == IDLE) && any_req &&
                ((req_size == 2'b11) ||
                 (req_read && req_write) ||
                 (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00));
      legal         = (state == IDLE) && any_req && !err_c;
      is_load       = legal && req_read;
      is_word_store = legal && req_write && (req_size == 2'b10);
      is_sub_store  = legal && req_write && (req_size != 2'b10);
   end

   // Lane position/width shared by load extraction and store merging
   always_comb begin
      case (req_size)
         2'b00: begin
            shift     = {req_addr[1:0], 3'b000};
            lane_mask = 32'h0000_00FF;
         end
         2'b01: begin
            shift     = {req_addr[1], 4'b0000};
            lane_mask = 32'h0000_FFFF;
         end
         default: begin
            shift     = 5'd0;
            lane_mask = '1;
         end
      endcase
      lane_raw = (mem_rdata >> shift) & lane_mask;
      merged   = (mem_rdata & ~(lane_mask << shift)) | ((req_wdata & lane_mask) << shift);
      case (req_size)
         2'b00:   load_ext = req_unsigned ? {24'h0, lane_raw[7:0]}
                                          : {{24{lane_raw[7]}}, lane_raw[7:0]};
         2'b01:   load_ext = req_unsigned ? {16'h0, lane_raw[15:0]}
                                          : {{16{lane_raw[15]}}, lane_raw[15:0]};
         default: load_ext = lane_raw;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         lat_addr <= '0;
         lat_data <= '0;
      end else begin
         state <= state_nxt;
         if (is_sub_store) begin
            lat_addr <= {req_addr[31:2], 2'b00};
            lat_data <= merged;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (is_sub_store) state_nxt = MERGE;
         MERGE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      load_data = '0;
      stall     = 1'b0;
      err       = err_c;
      case (state)
         IDLE: begin
            if (legal) mem_addr = {req_addr[31:2], 2'b00};
            if (is_load) begin
               mem_read  = 1'b1;
               load_data = load_ext;
            end
            if (is_word_store) begin
               mem_write = 1'b1;
               mem_wdata = req_wdata;
            end
            if (is_sub_store) begin
               mem_read = 1'b1;
               stall    = 1'b1;
            end
         end
         MERGE: begin
            mem_addr  = lat_addr;
            mem_wdata = lat_data;
            // A reset landing on the write cycle suppresses the write
            mem_write = !reset;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         err_count <= '0;
      else if (err && err_count != '1)
         err_count <= err_count + ERR_CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a word-array memory and a
// shift/mask reference model of byte-lane loads, stores and error counting.
module tb_mem_access_unit;

   localparam int unsigned W      = 8;
   localparam int unsigned CNTMAX = (1 << W) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_read, req_write, req_unsigned;
   logic [1:0]    req_size;
   logic [31:0]   req_addr, req_wdata, mem_rdata;
   logic [31:0]   mem_addr, mem_wdata, load_data;
   logic          mem_read, mem_write, stall, err;
   logic [W-1:0]  err_count;

   logic [31:0]   sim_mem [256];
   logic [31:0]   ref_mem [256];
   int unsigned   ref_cnt;
   int            n_tests = 0;
   int            n_fail  = 0;

   mem_access_unit #(.ERR_CNT_WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .req_read(req_read), .req_write(req_write), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .load_data(load_data),
      .stall(stall), .err(err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   assign mem_rdata = sim_mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_write) sim_mem[mem_addr[9:2]] <= mem_wdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_req(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd);
      req_read = rd; req_write = wr; req_size = sz;
      req_unsigned = uns; req_addr = addr; req_wdata = wd;
   endtask

   // One request issued at negedge; a sub-word store also runs its write cycle,
   // during which random junk is driven on the request inputs.
   task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] ld_obs);
      logic        bad;
      logic [31:0] word, mask, lane, exp_ld, merged, waddr;
      int unsigned sh;
      @(negedge clk);
      set_req(rd, wr, sz, uns, addr, wd);
      #2;
      bad    = (rd || wr) && (sz == 2'b11 || (rd && wr) ||
                              (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00));
      waddr  = addr & 32'hFFFF_FFFC;
      word   = ref_mem[addr[9:2]];
      sh     = (sz == 2'b00) ? int'(addr[1:0]) * 8 : (sz == 2'b01) ? int'(addr[1]) * 16 : 0;
      mask   = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
      lane   = (word >> sh) & mask;
      exp_ld = lane;
      if (!uns && sz == 2'b00 && lane[7])  exp_ld = exp_ld | 32'hFFFF_FF00;
      if (!uns && sz == 2'b01 && lane[15]) exp_ld = exp_ld | 32'hFFFF_0000;
      merged = (word & ~(mask << sh)) | ((wd & mask) << sh);
      ld_obs = load_data;

      check("err_count", {24'h0, err_count}, ref_cnt);
      check("err", {31'h0, err}, {31'h0, bad});
      if (bad || !(rd || wr)) begin
         check("idle_read", {31'h0, mem_read}, 32'd0);
         check("idle_write", {31'h0, mem_write}, 32'd0);
         check("idle_stall", {31'h0, stall}, 32'd0);
         check("idle_ld", load_data, 32'd0);
         check("idle_addr", mem_addr, 32'd0);
      end else if (rd) begin
         check("ld_read", {31'h0, mem_read}, 32'd1);
         check("ld_write", {31'h0, mem_write}, 32'd0);
         check("ld_stall", {31'h0, stall}, 32'd0);
         check("ld_addr", mem_addr, waddr);
         check("ld_data", load_data, exp_ld);
      end else if (sz == 2'b10) begin
         check("sw_write", {31'h0, mem_write}, 32'd1);
         check("sw_read", {31'h0, mem_read}, 32'd0);
         check("sw_stall", {31'h0, stall}, 32'd0);
         check("sw_addr", mem_addr, waddr);
         check("sw_wdata", mem_wdata, wd);
      end else begin
         check("rmw1_read", {31'h0, mem_read}, 32'd1);
         check("rmw1_write", {31'h0, mem_write}, 32'd0);
         check("rmw1_stall", {31'h0, stall}, 32'd1);
         check("rmw1_addr", mem_addr, waddr);
      end
      @(posedge clk);
      if (bad && ref_cnt < CNTMAX) ref_cnt++;
      if (!bad && wr && sz == 2'b10) ref_mem[addr[9:2]] = wd;
      if (!bad && wr && sz != 2'b10) begin
         @(negedge clk);
         set_req($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1), $urandom, $urandom);
         #2;
         check("rmw2_write", {31'h0, mem_write}, 32'd1);
         check("rmw2_read", {31'h0, mem_read}, 32'd0);
         check("rmw2_stall", {31'h0, stall}, 32'd0);
         check("rmw2_err", {31'h0, err}, 32'd0);
         check("rmw2_addr", mem_addr, waddr);
         check("rmw2_wdata", mem_wdata, merged);
         @(posedge clk);
         ref_mem[addr[9:2]] = merged;
      end
   endtask

   logic [31:0] ld;

   initial begin
      for (int i = 0; i < 256; i++) begin
         sim_mem[i] = $urandom;
         ref_mem[i] = sim_mem[i];
      end
      ref_cnt = 0;
      reset   = 1'b1;
      set_req(0, 0, 2'b00, 0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      do_req(0, 0, 2'b00, 0, 32'h0, 32'h0, ld);                    // reset / idle state

      do_req(0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, ld);
      do_req(1, 0, 2'b10, 0, 32'h10, 32'h0, ld);
      check("tp_lw", ld, 32'hDEAD_BEEF);
      do_req(0, 1, 2'b10, 0, 32'h10, 32'h1122_3344, ld);
      do_req(0, 1, 2'b00, 0, 32'h12, 32'h0000_00AA, ld);
      do_req(1, 0, 2'b10, 0, 32'h10, 32'h0, ld);
      check("tp_sb_result", ld, 32'h11AA_3344);

      do_req(0, 1, 2'b10, 0, 32'h20, 32'h80F0_1234, ld);
      do_req(1, 0, 2'b01, 0, 32'h22, 32'h0, ld);
      check("tp_lh", ld, 32'hFFFF_80F0);
      do_req(1, 0, 2'b01, 1, 32'h22, 32'h0, ld);
      check("tp_lhu", ld, 32'h0000_80F0);
      do_req(1, 0, 2'b00, 0, 32'h21, 32'h0, ld);
      check("tp_lb", ld, 32'h0000_0012);
      do_req(1, 0, 2'b00, 1, 32'h23, 32'h0, ld);
      check("tp_lbu", ld, 32'h0000_0080);

      do_req(1, 0, 2'b10, 0, 32'h21, 32'h0, ld);                   // misaligned word
      do_req(0, 1, 2'b01, 0, 32'h23, 32'h5555, ld);                // misaligned half
      do_req(1, 0, 2'b11, 0, 32'h40, 32'h0, ld);                   // illegal size
      do_req(1, 1, 2'b10, 0, 32'h40, 32'h0, ld);                   // read+write
      @(negedge clk);
      set_req(0, 0, 2'b00, 0, 32'h0, 32'h0);
      #2;
      check("tp_err4", {24'h0, err_count}, 32'd4);

      do_req(0, 1, 2'b10, 0, 32'h30, 32'h0102_0304, ld);
      do_req(0, 1, 2'b01, 0, 32'h30, 32'h0000_BEEF, ld);
      do_req(0, 1, 2'b00, 0, 32'h31, 32'h0000_0077, ld);
      do_req(1, 0, 2'b10, 0, 32'h30, 32'h0, ld);
      check("tp_b2b", ld, 32'h0102_77EF);

      for (int i = 0; i < 400; i++)
         do_req($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 50,
                2'($urandom_range(0, 3)), $urandom_range(0, 1),
                $urandom_range(0, 1023), $urandom, ld);

      // reset landing on the write cycle of a byte store
      do_req(0, 1, 2'b10, 0, 32'h50, 32'hCAFE_F00D, ld);
      @(negedge clk);
      set_req(0, 1, 2'b00, 0, 32'h51, 32'h0000_0011);
      #2;
      check("rst_rmw1_stall", {31'h0, stall}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      set_req(0, 0, 2'b00, 0, 32'h0, 32'h0);
      reset = 1'b1;
      #2;
      check("rst_merge_write", {31'h0, mem_write}, 32'd0);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      ref_cnt = 0;
      do_req(0, 0, 2'b00, 0, 32'h0, 32'h0, ld);
      do_req(1, 0, 2'b10, 0, 32'h50, 32'h0, ld);
      check("rst_mem_kept", ld, 32'hCAFE_F00D);

      for (int i = 0; i < 300; i++)
         do_req(1, 0, 2'b11, 0, $urandom, 32'h0, ld);
      @(negedge clk);
      set_req(0, 0, 2'b00, 0, 32'h0, 32'h0);
      #2;
      check("err_sat", {24'h0, err_count}, CNTMAX);
      do_req(1, 1, 2'b00, 0, 32'h0, 32'h0, ld);
      do_req(0, 0, 2'b00, 0, 32'h0, 32'h0, ld);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
